// File: rtl/btn_cond_pkg.sv
// Shared types, default cycle counts and sizing helpers for the button conditioner.
// The BTN_AUTOREPEAT_EN macro selects whether held keys produce repeat pulses.
package btn_cond_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPressDb,
        StPulse,
        StHeld,
        StRelDb
    } btn_state_e;

    // Defaults for a 50 MHz clock.
    localparam int unsigned DefDebounceCyc = 500000;   // 10 ms
    localparam int unsigned DefPulseCyc    = 1000000;  // 20 ms
    localparam int unsigned DefHoldCyc     = 25000000; // 500 ms
    localparam int unsigned DefRepeatCyc   = 5000000;  // 100 ms

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold values 0..max_val (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/button_channel.sv
// One key channel: 2-FF synchronizer, debounce FSM and guaranteed-width press pulse.
// With BTN_AUTOREPEAT_EN defined, a held key re-pulses after HOLD_CYC, then every REPEAT_CYC.
module button_channel
    import btn_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DefDebounceCyc,
    parameter int unsigned PULSE_CYC    = DefPulseCyc,
    parameter int unsigned HOLD_CYC     = DefHoldCyc,
    parameter int unsigned REPEAT_CYC   = DefRepeatCyc
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic press_i,
    output logic pulse_o,
    output logic held_o
);

    if (DEBOUNCE_CYC == 0 || PULSE_CYC == 0 || PULSE_CYC >= REPEAT_CYC
        || REPEAT_CYC > HOLD_CYC) begin : g_bad_params
        $error("button_channel: illegal cycle-count parameters");
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned CntMax = max_u(max_u(DEBOUNCE_CYC, PULSE_CYC), HOLD_CYC);
`else
    localparam int unsigned CntMax = max_u(DEBOUNCE_CYC, PULSE_CYC);
`endif
    localparam int unsigned CntW = cnt_width(CntMax);

    localparam logic [CntW-1:0] CntOne    = CntW'(1);
    localparam logic [CntW-1:0] CntSat    = '1;
    localparam logic [CntW-1:0] DebCnt    = CntW'(DEBOUNCE_CYC);
    localparam logic [CntW-1:0] PulseLast = CntW'(PULSE_CYC - 1);
`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CntW-1:0] HoldLast   = CntW'(HOLD_CYC - 1);
    localparam logic [CntW-1:0] RepeatLast = CntW'(REPEAT_CYC - 1);
`endif

    logic            sync1_q, sync2_q;
    btn_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
`ifdef BTN_AUTOREPEAT_EN
    logic            first_q, first_d;
`endif

    assign cnt_inc = (cnt_q == CntSat) ? cnt_q : cnt_q + CntOne;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= StIdle;
            cnt_q   <= '0;
`ifdef BTN_AUTOREPEAT_EN
            first_q <= 1'b0;
`endif
        end else begin
            sync1_q <= press_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
`ifdef BTN_AUTOREPEAT_EN
            first_q <= first_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_inc;
`ifdef BTN_AUTOREPEAT_EN
        first_d = first_q;
`endif
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (sync2_q) begin
                    state_d = StPressDb;
                    cnt_d   = CntOne;
                end
            end
            StPressDb: begin
                if (!sync2_q) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == DebCnt) begin
                    state_d = StPulse;
                    cnt_d   = '0;
`ifdef BTN_AUTOREPEAT_EN
                    first_d = 1'b1;
`endif
                end
            end
            // Key level is ignored here so the pulse always has its full width.
            StPulse: begin
                if (cnt_q == PulseLast) begin
                    state_d = StHeld;
                end
            end
            StHeld: begin
                if (!sync2_q) begin
                    state_d = StRelDb;
                    cnt_d   = CntOne;
`ifdef BTN_AUTOREPEAT_EN
                end else if (cnt_q == (first_q ? HoldLast : RepeatLast)) begin
                    state_d = StPulse;
                    cnt_d   = '0;
                    first_d = 1'b0;
`endif
                end
            end
            StRelDb: begin
                if (sync2_q) begin
                    state_d = StHeld;
                    cnt_d   = '0;
                end else if (cnt_q == DebCnt) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    assign pulse_o = (state_q == StPulse);
    assign held_o  = (state_q == StPulse) || (state_q == StHeld) || (state_q == StRelDb);

endmodule

// File: rtl/button_conditioner.sv
// Conditions N_BTN raw push-button pins into debounced held levels and CPU-visible press pulses.
// Define BTN_AUTOREPEAT_EN to enable hold-to-auto-repeat pulses.
module button_conditioner
    import btn_cond_pkg::*;
#(
    parameter int unsigned N_BTN          = 4,
    parameter bit          KEY_ACTIVE_LOW = 1'b1,
    parameter int unsigned DEBOUNCE_CYC   = DefDebounceCyc,
    parameter int unsigned PULSE_CYC      = DefPulseCyc,
    parameter int unsigned HOLD_CYC       = DefHoldCyc,
    parameter int unsigned REPEAT_CYC     = DefRepeatCyc
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic [N_BTN-1:0] key_n,
    output logic [N_BTN-1:0] btn_pulse,
    output logic [N_BTN-1:0] btn_held
);

    // Inverting by a constant is glitch-free, so normalizing before the synchronizer is safe.
    logic [N_BTN-1:0] press_raw;
    assign press_raw = KEY_ACTIVE_LOW ? ~key_n : key_n;

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        button_channel #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .PULSE_CYC    (PULSE_CYC),
            .HOLD_CYC     (HOLD_CYC),
            .REPEAT_CYC   (REPEAT_CYC)
        ) u_chan (
            .clk_i   (clk_clk),
            .rst_ni  (reset_reset_n),
            .press_i (press_raw[i]),
            .pulse_o (btn_pulse[i]),
            .held_o  (btn_held[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: directed scenarios plus randomized key activity
// checked against a timestamp/run-length reference model. Honours BTN_AUTOREPEAT_EN.
module tb_button_conditioner;

    localparam int N = 4;
    localparam int D = 4;
    localparam int P = 3;
    localparam int H = 20;
    localparam int R = 8;

    logic         clk_clk       = 1'b0;
    logic         reset_reset_n = 1'b0;
    logic [N-1:0] key_n         = '1;
    logic [N-1:0] btn_pulse;
    logic [N-1:0] btn_held;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk_clk = ~clk_clk;

    button_conditioner #(
        .N_BTN          (N),
        .KEY_ACTIVE_LOW (1'b1),
        .DEBOUNCE_CYC   (D),
        .PULSE_CYC      (P),
        .HOLD_CYC       (H),
        .REPEAT_CYC     (R)
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .key_n         (key_n),
        .btn_pulse     (btn_pulse),
        .btn_held      (btn_held)
    );

    // Reference model: pin delay line, run lengths of pressed/released samples, pulse start time.
    bit           ms1[N], ms2[N], mheld[N];
    int           mrun[N], mrel[N], mpstart[N];
`ifdef BTN_AUTOREPEAT_EN
    int           mbase[N];
    bit           mfirst[N];
`endif
    logic [N-1:0] exp_pulse = '0;
    logic [N-1:0] exp_held  = '0;

    task automatic model_step();
        for (int i = 0; i < N; i++) begin
            bit p;
            if (!reset_reset_n) begin
                ms1[i] = 1'b0; ms2[i] = 1'b0; mheld[i] = 1'b0;
                mrun[i] = 0; mrel[i] = 0; mpstart[i] = -1000;
            end else begin
                p      = ms2[i];
                ms2[i] = ms1[i];
                ms1[i] = ~key_n[i];
                if (!mheld[i]) begin
                    mrun[i] = p ? mrun[i] + 1 : 0;
                    // Accept after DEBOUNCE_CYC+1 consecutive pressed samples.
                    if (mrun[i] == D + 1) begin
                        mheld[i] = 1'b1; mpstart[i] = cyc; mrun[i] = 0; mrel[i] = 0;
`ifdef BTN_AUTOREPEAT_EN
                        mbase[i] = cyc; mfirst[i] = 1'b1;
`endif
                    end
                end else if (cyc - mpstart[i] <= P) begin
                    // pulse in progress: key level ignored
                end else if (!p) begin
                    mrel[i]++;
                    if (mrel[i] == D + 1) begin
                        mheld[i] = 1'b0; mrel[i] = 0;
                    end
                end else if (mrel[i] > 0) begin
                    mrel[i] = 0;
`ifdef BTN_AUTOREPEAT_EN
                    mbase[i] = cyc;
                end else if (cyc - mbase[i] == (mfirst[i] ? H : R)) begin
                    mpstart[i] = cyc; mbase[i] = cyc; mfirst[i] = 1'b0;
`endif
                end
            end
            exp_held[i]  = mheld[i];
            exp_pulse[i] = mheld[i] && (cyc >= mpstart[i]) && (cyc - mpstart[i] < P);
        end
    endtask

    task automatic tick();
        @(posedge clk_clk);
        cyc++;
        model_step();
        #1;
    endtask

    task automatic do_reset();
        reset_reset_n = 1'b0;
        key_n         = '1;
        tick();
        tick();
        reset_reset_n = 1'b1;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        reset_reset_n = 1'b0;
        key_n         = '0;
        for (int k = 0; k < 10; k++) begin
            if (k == 3) reset_reset_n = 1'b1;
            // Pressed during reset: no output until a full debounce after release of reset.
            total++;
            if (btn_pulse !== 4'h0 || btn_held !== 4'h0) begin
                bad++;
                $display("FAIL reset k=%0d pulse=%b held=%b want 0000/0000", k, btn_pulse,
                         btn_held);
            end
            tick();
        end
        do_reset();
    endtask

    task automatic test_clean_press();
        logic [N-1:0] ep, eh;
        do_reset();
        for (int k = 0; k < 25; k++) begin
            key_n = {3'b111, (k >= 12)};
            ep = {3'b000, (k >= 7 && k <= 9)};
            eh = {3'b000, (k >= 7 && k < 19)};
            total++;
            if (btn_pulse !== ep || btn_held !== eh) begin
                bad++;
                $display("FAIL clean_press k=%0d pulse=%b held=%b want %b/%b", k, btn_pulse,
                         btn_held, ep, eh);
            end
            tick();
        end
    endtask

    task automatic test_bounce();
        do_reset();
        for (int k = 0; k < 20; k++) begin
            key_n[1] = !((k <= 2) || (k >= 5 && k <= 7));
            total++;
            if (btn_pulse !== 4'h0 || btn_held !== 4'h0) begin
                bad++;
                $display("FAIL bounce k=%0d pulse=%b held=%b want 0000/0000", k, btn_pulse,
                         btn_held);
            end
            tick();
        end
    endtask

    task automatic test_autorepeat();
`ifdef BTN_AUTOREPEAT_EN
        int starts[6] = '{7, 27, 35, 43, 51, 59};
`else
        int starts[1] = '{7};
`endif
        logic [N-1:0] ep, eh;
        bit hit;
        do_reset();
        for (int k = 0; k < 75; k++) begin
            key_n[2] = (k >= 60);
            hit = 1'b0;
            foreach (starts[j]) if (k >= starts[j] && k < starts[j] + P) hit = 1'b1;
            ep = {1'b0, hit, 2'b00};
            eh = {1'b0, (k >= 7 && k < 67), 2'b00};
            total++;
            if (btn_pulse !== ep || btn_held !== eh) begin
                bad++;
                $display("FAIL autorepeat k=%0d pulse=%b held=%b want %b/%b", k, btn_pulse,
                         btn_held, ep, eh);
            end
            tick();
        end
    endtask

    task automatic test_short_tap();
        logic [N-1:0] ep, eh;
        do_reset();
        for (int k = 0; k < 20; k++) begin
            key_n[3] = (k >= 6);
            ep = {(k >= 7 && k <= 9), 3'b000};
            // Release is only seen once HELD is reached at 10; 11..14 are the release samples.
            eh = {(k >= 7 && k < 15), 3'b000};
            total++;
            if (btn_pulse !== ep || btn_held !== eh) begin
                bad++;
                $display("FAIL short_tap k=%0d pulse=%b held=%b want %b/%b", k, btn_pulse,
                         btn_held, ep, eh);
            end
            tick();
        end
    endtask

    task automatic test_simultaneous();
        logic [N-1:0] ep, eh;
        do_reset();
        for (int k = 0; k < 23; k++) begin
            key_n = (k < 12) ? 4'h0 : 4'hF;
            ep = (k >= 7 && k <= 9) ? 4'hF : 4'h0;
            eh = (k >= 7 && k < 19) ? 4'hF : 4'h0;
            total++;
            if (btn_pulse !== ep || btn_held !== eh) begin
                bad++;
                $display("FAIL simultaneous k=%0d pulse=%b held=%b want %b/%b", k, btn_pulse,
                         btn_held, ep, eh);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_hold();
        logic [N-1:0] ep, eh;
        bit rep;
        do_reset();
`ifdef BTN_AUTOREPEAT_EN
        rep = 1'b1;
`else
        rep = 1'b0;
`endif
        for (int k = 0; k < 50; k++) begin
            key_n[0] = 1'b0;
            reset_reset_n = !(k == 30 || k == 31);
            ep = {3'b000, (k >= 7 && k <= 9) || (rep && k >= 27 && k <= 29)
                          || (k >= 39 && k <= 41)};
            eh = {3'b000, (k >= 7 && k <= 30) || (k >= 39)};
            total++;
            if (btn_pulse !== ep || btn_held !== eh) begin
                bad++;
                $display("FAIL reset_mid_hold k=%0d pulse=%b held=%b want %b/%b", k, btn_pulse,
                         btn_held, ep, eh);
            end
            tick();
        end
        reset_reset_n = 1'b1;
        key_n         = '1;
    endtask

    task automatic test_random();
        int dur[N];
        do_reset();
        foreach (dur[i]) dur[i] = $urandom_range(1, 12);
        for (int k = 0; k < 4000; k++) begin
            for (int i = 0; i < N; i++) begin
                dur[i]--;
                if (dur[i] == 0) begin
                    key_n[i] = ~key_n[i];
                    dur[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4)
                                                         : $urandom_range(5, 60);
                end
            end
            reset_reset_n = ($urandom_range(0, 599) != 0);
            total++;
            if (btn_pulse !== exp_pulse || btn_held !== exp_held) begin
                bad++;
                $display("FAIL random k=%0d key_n=%b pulse=%b held=%b want %b/%b", k, key_n,
                         btn_pulse, btn_held, exp_pulse, exp_held);
            end
            tick();
        end
        reset_reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_autorepeat();
        test_short_tap();
        test_simultaneous();
        test_reset_mid_hold();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
